ni_write_arbiter: RTL
=====================

# ni_write_arbiter

Round-robin arbiter that shares the single core-side write port of the network interface (`ni`) between several local requesters (cores, DMA, config master). Each requester offers a multi-flit packet over a valid/ready handshake. The arbiter locks the grant for the whole packet and drives the NI's `core_write_en` / `core_write_addr` / `core_write_data` from a registered output stage. A watchdog releases a grant held by a requester that stalls mid-packet.

## Interface
- `NUM_REQ`, 4: number of requesters (≥1).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: consecutive stalled LOCK cycles before forced release (≥2).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i offers a flit.
- `req_last`  in  NUM_REQ  flit is the last of its packet.
- `req_addr`  in  NUM_REQ*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*DATA_W  flat; requester i at [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  flit of requester i accepted this cycle.
- `ni_ready`  in  1  NI can accept a write this cycle (FIFO not full).
- `core_write_en`  out  1  one-cycle write strobe to NI.
- `core_write_addr`  out  ADDR_W  write address to NI.
- `core_write_data`  out  DATA_W  write data to NI.
- `grant_id`  out  max(1,$clog2(NUM_REQ))  currently/last granted requester.
- `busy`  out  1  state is LOCK.
- `timeout_err`  out  1  one-cycle pulse on watchdog release.

## Operation
- States: IDLE, LOCK.
- IDLE:
  - `req_ready` all 0.
  - If any `req_valid`, select the first valid index scanning `rr_ptr`, `rr_ptr`+1, … wrapping mod NUM_REQ.
  - Register it into `grant_id`, clear the stall counter, and go to LOCK.
  - No valid requesters: stay in IDLE.
- LOCK:
  - `req_ready[grant_id]` = `ni_ready` (combinational); all other bits 0.
  - Transfer when `req_valid[grant_id] && req_ready[grant_id]`.
  - On transfer, register the granted addr/data into the output stage and set `core_write_en`=1 for the next cycle.
  - Transfer with `req_last`: go to IDLE; `rr_ptr` ← (`grant_id`+1) mod NUM_REQ.
  - Transfer without `req_last`: stay in LOCK; stall counter ← 0.
- Watchdog (LOCK only):
  - Counter increments on each LOCK cycle with `req_valid[grant_id]`=0.
  - It holds (no increment, no clear) when valid is high but `ni_ready`=0. NI backpressure never times out.
  - When the counter reaches TIMEOUT: go to IDLE, `rr_ptr` ← `grant_id`+1, pulse `timeout_err`.
- `core_write_en` = 0 in every cycle not immediately following a transfer.
- `core_write_addr` / `core_write_data` hold their last values when `core_write_en`=0.
- Requesters keep addr/data/last stable while valid and not ready. The arbiter does not check this.
- NUM_REQ=1: `rr_ptr` and `grant_id` are constant 0.

## Timing
- Reset values:
  - state IDLE; `rr_ptr`, `grant_id`, stall counter 0.
  - `core_write_en` 0; `core_write_addr` and `core_write_data` 0.
  - `busy` 0; `timeout_err` 0; `req_ready` 0.
- Reset has priority over every other event. Reset mid-packet drops any flit in the output stage: `core_write_en`=0 in the cycle after reset. The partial packet is not completed.
- Arbitration latency: valid seen in IDLE in cycle N → LOCK in N+1, earliest `req_ready` in N+1.
- Write latency: transfer in cycle T → `core_write_en`=1 in T+1.
- Throughput: one flit per cycle while locked. One IDLE bubble between packets; a packet of n flits occupies n+1 cycles minimum.
- `req_last` transfer in T → IDLE in T+1, next grant LOCK in T+2.
- Watchdog: the TIMEOUT-th stalled cycle at T → IDLE and `timeout_err`=1 in T+1, pulse cleared in T+2.
- A flit transferred in the same cycle the counter would reach TIMEOUT wins: the transfer happens and the counter clears.

## Test plan
- **Reset:** reset high 2 cycles with all `req_valid`=1 and `ni_ready`=1 → all outputs 0, `busy` 0, no `req_ready` during or in the cycle after reset.
- **Single flit:** req0 valid, last=1, addr 0xA5A5A5A5, data 0xAAAAAAAA, `ni_ready`=1 from cycle 0.
  - Cycle 1: `req_ready[0]`=1, `busy`=1.
  - Cycle 2: `core_write_en`=1 with 0xA5A5A5A5 / 0xAAAAAAAA, `busy`=0.
- **Round-robin:** all four requesters continuously valid with single-flit packets → grant order 0,1,2,3,0, one write every 2 cycles, no requester starved.
- **Packet lock:** req2 sends a 3-flit packet (data 0x1,0x2,0x3) while req1 is valid.
  - 3 consecutive writes 0x1, 0x2, 0x3 with `grant_id`=2 throughout.
  - Then the next grant goes to req1: scan order 3,0,1 with 3 and 0 idle.
- **Backpressure:** `ni_ready`=0 for 20 cycles mid-packet → no `req_ready`, no `core_write_en`, no `timeout_err`. The packet resumes and completes when `ni_ready` returns to 1.
- **Watchdog:** req0 drops valid after flit 1 of a 4-flit packet; req3 valid. TIMEOUT=16.
  - `timeout_err` pulses 1 cycle after the 16th stalled cycle.
  - The arbiter returns to IDLE and then grants req3.

Source files
------------

// File: rtl/ni_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_write_arbiter_if
// Description : Requester and NI-side write signals of the write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ni_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      ni_ready;
    logic                      core_write_en;
    logic [ADDR_W-1:0]         core_write_addr;
    logic [DATA_W-1:0]         core_write_data;
    logic [GRANT_W-1:0]        grant_id;
    logic                      busy;
    logic                      timeout_err;

    // Arbiter side
    modport slave (
        input  req_valid, req_last, req_addr, req_data, ni_ready,
        output req_ready, core_write_en, core_write_addr, core_write_data,
               grant_id, busy, timeout_err
    );

    // Requester / NI side
    modport master (
        output req_valid, req_last, req_addr, req_data, ni_ready,
        input  req_ready, core_write_en, core_write_addr, core_write_data,
               grant_id, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/ni_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ni_write_arbiter
// Description : Packet-locked round-robin arbiter for the NI core write port,
//               with a stall watchdog that releases abandoned grants.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input wire              clk,
    input wire              reset,
    ni_write_arbiter_if.slave bus
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_LOCK = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] r_grant_id;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_core_write_en;
    logic [ADDR_W-1:0]  r_core_write_addr;
    logic [DATA_W-1:0]  r_core_write_data;
    logic               r_timeout_err;

    logic [GRANT_W-1:0] w_pick;
    logic               w_any_valid;
    logic               w_gnt_valid;
    logic               w_gnt_last;
    logic               w_xfer;
    logic               w_stall;
    logic               w_timeout;

    // (base + off) mod NUM_REQ for off < NUM_REQ, safe for non-power-of-two counts
    function automatic logic [GRANT_W-1:0] f_wrap(input logic [GRANT_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return GRANT_W'(sum);
    endfunction

    // Descending scan so the smallest offset from rr_ptr wins
    always_comb begin
        w_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[f_wrap(r_rr_ptr, k)]) w_pick = f_wrap(r_rr_ptr, k);
        end
    end

    assign w_any_valid = |bus.req_valid;
    assign w_gnt_valid = bus.req_valid[r_grant_id];
    assign w_gnt_last  = bus.req_last[r_grant_id];
    assign w_xfer      = (r_state == c_LOCK) && w_gnt_valid && bus.ni_ready;
    assign w_stall     = (r_state == c_LOCK) && !w_gnt_valid;
    assign w_timeout   = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_any_valid) w_next_state = c_LOCK;
            c_LOCK: if ((w_xfer && w_gnt_last) || w_timeout) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.busy      = (r_state == c_LOCK);
        if (r_state == c_LOCK) bus.req_ready[r_grant_id] = bus.ni_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr          <= '0;
            r_grant_id        <= '0;
            r_stall_cnt       <= '0;
            r_core_write_en   <= 1'b0;
            r_core_write_addr <= '0;
            r_core_write_data <= '0;
            r_timeout_err     <= 1'b0;
        end else begin
            r_core_write_en <= w_xfer;
            r_timeout_err   <= w_timeout;
            if (w_xfer) begin
                r_core_write_addr <= bus.req_addr[r_grant_id*ADDR_W +: ADDR_W];
                r_core_write_data <= bus.req_data[r_grant_id*DATA_W +: DATA_W];
            end
            if (r_state == c_IDLE) begin
                if (w_any_valid) begin
                    r_grant_id  <= w_pick;
                    r_stall_cnt <= '0;
                end
            end else begin
                // Backpressure (valid high, ni_ready low) leaves the counter untouched
                if (w_xfer) begin
                    r_stall_cnt <= '0;
                    if (w_gnt_last) r_rr_ptr <= f_wrap(r_grant_id, 1);
                end else if (w_timeout) begin
                    r_stall_cnt <= '0;
                    r_rr_ptr    <= f_wrap(r_grant_id, 1);
                end else if (w_stall) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.core_write_en   = r_core_write_en;
    assign bus.core_write_addr = r_core_write_addr;
    assign bus.core_write_data = r_core_write_data;
    assign bus.grant_id        = r_grant_id;
    assign bus.timeout_err     = r_timeout_err;

endmodule
`default_nettype wire
